// File: rtl/posit_top.sv
// Posit sign-injection / min-max / compare / classify unit; arithmetic ops return NaR with NV.
// Optional classify support is compiled in with POSIT_TOP_CLASSIFY_EN.

package posit_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FMSUB    = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9
  } operation_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

module posit_top #(
  parameter int WIDTH        = 32,
  parameter int ES           = 2,
  parameter int NUM_OPERANDS = 3
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_OPERANDS-1:0][WIDTH-1:0]  operands_i,
  input  posit_pkg::roundmode_e               rnd_mode_i,
  input  posit_pkg::operation_e               op_i,
  input  logic                                op_mod_i,
  input  logic [2:0]                          src_fmt_i,
  input  logic [2:0]                          dst_fmt_i,
  input  logic [1:0]                          int_fmt_i,
  input  logic                                vectorial_op_i,
  input  logic                                simd_mask_i,
  input  logic                                tag_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic                                flush_i,
  output logic [WIDTH-1:0]                    result_o,
  output posit_pkg::status_t                  status_o,
  output logic                                tag_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                busy_o
);
  // Purpose: one-stage posit sign/order/classify ops; other opcodes yield NaR + NV.
  // Latency: one cycle from accept to out_valid_o.
  // Backpressure: single output register; input stalls while it holds an unconsumed result.

  import posit_pkg::*;

  localparam logic [WIDTH-1:0] NAR  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam int               ES_W = ES;

  logic [WIDTH-1:0] op0, op1;
  logic [WIDTH-1:0] op0_neg, mag, mag_neg;
  logic             op0_is_zero, op0_is_nar;
  logic             lt, eq;
  logic             sgn;
  logic             accept;

  logic [WIDTH-1:0] calc_res;
  status_t          calc_stat;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  status_t          status_q, status_d;
  logic             tag_q, tag_d;

  logic unused_inputs;
  assign unused_inputs = ^{operands_i, op_mod_i, src_fmt_i, dst_fmt_i, int_fmt_i,
                           vectorial_op_i, simd_mask_i, ES_W[0]};

  assign op0         = operands_i[0];
  assign op1         = operands_i[1];
  assign op0_is_zero = (op0 == '0);
  assign op0_is_nar  = (op0 == NAR);
  assign op0_neg     = ~op0 + ONE;
  assign mag         = op0[WIDTH-1] ? op0_neg : op0;
  assign mag_neg     = ~mag + ONE;

  // NaR is the most negative two's-complement word, so plain signed order handles it.
  assign lt = ($signed(op0) < $signed(op1));
  assign eq = (op0 == op1);

  always_comb begin
    sgn = 1'b0;
    case (rnd_mode_i)
      RNE:     sgn = op1[WIDTH-1];
      RTZ:     sgn = ~op1[WIDTH-1];
      RDN:     sgn = op0[WIDTH-1] ^ op1[WIDTH-1];
      default: sgn = 1'b0;
    endcase
  end

  always_comb begin
    calc_res  = '0;
    calc_stat = '0;
    case (op_i)
      SGNJ: begin
        if (rnd_mode_i == RNE || rnd_mode_i == RTZ || rnd_mode_i == RDN) begin
          if (op0_is_zero || op0_is_nar) calc_res = op0;
          else                           calc_res = sgn ? mag_neg : mag;
        end else begin
          calc_stat.nv = 1'b1;
        end
      end
      MINMAX: begin
        case (rnd_mode_i)
          RNE:     calc_res = lt ? op0 : op1;
          RTZ:     calc_res = lt ? op1 : op0;
          default: calc_stat.nv = 1'b1;
        endcase
      end
      CMP: begin
        case (rnd_mode_i)
          RNE:     calc_res = {{(WIDTH-1){1'b0}}, lt | eq};
          RTZ:     calc_res = {{(WIDTH-1){1'b0}}, lt};
          RDN:     calc_res = {{(WIDTH-1){1'b0}}, eq};
          default: calc_stat.nv = 1'b1;
        endcase
      end
`ifdef POSIT_TOP_CLASSIFY_EN
      CLASSIFY: begin
        if (op0_is_zero)        calc_res = WIDTH'(1);
        else if (op0_is_nar)    calc_res = WIDTH'(2);
        else if (!op0[WIDTH-1]) calc_res = WIDTH'(4);
        else                    calc_res = WIDTH'(8);
      end
`endif
      default: begin
        calc_res     = NAR;
        calc_stat.nv = 1'b1;
      end
    endcase
  end

  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    status_d    = status_q;
    tag_d       = tag_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d    = calc_res;
      status_d    = calc_stat;
      tag_d       = tag_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      tag_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign status_o    = status_q;
  assign tag_o       = tag_q;
  assign busy_o      = out_valid_q;

endmodule

// File: tb/tb_posit_top.sv
// Scoreboard bench for posit_top: driver pushes expectations, monitor pops on output handshake.
module tb_posit_top;
  import posit_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] NAR = 32'h8000_0000;
  localparam logic [4:0]   NV  = 5'b10000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0][W-1:0]  operands;
  roundmode_e         rnd_mode;
  operation_e         op;
  logic               tag_in, in_valid, in_ready, flush;
  logic [W-1:0]       result;
  status_t            status;
  logic               tag_out, out_valid, out_ready, busy;

  always #5 clk = ~clk;

  posit_top #(.WIDTH(32), .ES(2), .NUM_OPERANDS(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .operands_i(operands), .rnd_mode_i(rnd_mode), .op_i(op),
    .op_mod_i(1'b0), .src_fmt_i(3'd0), .dst_fmt_i(3'd0), .int_fmt_i(2'd0),
    .vectorial_op_i(1'b0), .simd_mask_i(1'b0), .tag_i(tag_in),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .result_o(result), .status_o(status), .tag_o(tag_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [4:0]   st;
    logic         tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [4:0] st_act;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        e      = sb_q.pop_front();
        st_act = status;
        check({e.name, "_res"}, result, e.res);
        check({e.name, "_status"}, W'(st_act), W'(e.st));
        check({e.name, "_tag"}, W'(tag_out), W'(e.tag));
      end
    end
  end

  task automatic issue(input string name, input operation_e o, input roundmode_e rm,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [4:0] es);
    exp_t e;
    bit   done;
    int   n;
    done        = 1'b0;
    n           = 0;
    operands[0] = a;
    operands[1] = b;
    operands[2] = $urandom;
    op          = o;
    rnd_mode    = rm;
    tag_in      = ~tag_in;
    in_valid    = 1'b1;
    e.name = name; e.res = er; e.st = es; e.tag = tag_in;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        checks++;
        errors++;
        $display("FAIL %s_accept_timeout actual=in_ready_%b required=1", name, in_ready);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; tag_in = 1'b0;
    operands = '0; op = SGNJ; rnd_mode = RNE;
    idle(2);
    @(negedge clk);
    check("rst_valid", W'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_status", W'(5'(status)), 0);
    check("rst_tag", W'(tag_out), 0);
    check("rst_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue("sgnj_rne",    SGNJ, RNE, 32'h68E00000, 32'h48E00000, 32'h68E00000, 5'b0);
    issue("sgnj_rtz",    SGNJ, RTZ, 32'h68E00000, 32'h48E00000, 32'h97200000, 5'b0);
    issue("sgnj_rdn",    SGNJ, RDN, 32'h68E00000, 32'h48E00000, 32'h68E00000, 5'b0);
    issue("sgnj_negin",  SGNJ, RNE, 32'h97200000, 32'h48E00000, 32'h68E00000, 5'b0);
    issue("sgnj_rdn_nn", SGNJ, RDN, 32'h97200000, 32'h97200000, 32'h68E00000, 5'b0);
    issue("sgnj_zero",   SGNJ, RTZ, 32'h00000000, 32'h48E00000, 32'h00000000, 5'b0);
    issue("sgnj_nar",    SGNJ, RNE, NAR,          32'h48E00000, NAR,          5'b0);
    issue("sgnj_badrm",  SGNJ, RUP, 32'h68E00000, 32'h48E00000, 32'h00000000, NV);
    issue("min_rne",     MINMAX, RNE, 32'h68E00000, 32'h48E00000, 32'h48E00000, 5'b0);
    issue("max_rtz",     MINMAX, RTZ, 32'h68E00000, 32'h48E00000, 32'h68E00000, 5'b0);
    issue("min_nar",     MINMAX, RNE, 32'h48E00000, NAR,          NAR,          5'b0);
    issue("max_neg",     MINMAX, RTZ, 32'h97200000, 32'h00000000, 32'h00000000, 5'b0);
    issue("mm_badrm",    MINMAX, RDN, 32'h68E00000, 32'h48E00000, 32'h00000000, NV);
    issue("cmp_le",      CMP, RNE, 32'h68E00000, 32'h78E00000, 32'h1, 5'b0);
    issue("cmp_lt",      CMP, RTZ, 32'h68E00000, 32'h48E00000, 32'h0, 5'b0);
    issue("cmp_eq",      CMP, RDN, 32'h48E00000, 32'h48E00000, 32'h1, 5'b0);
    issue("cmp_le_eq",   CMP, RNE, 32'h48E00000, 32'h48E00000, 32'h1, 5'b0);
    issue("cmp_lt_nar",  CMP, RTZ, NAR,          32'h00000001, 32'h1, 5'b0);
    issue("cmp_badrm",   CMP, RMM, 32'h48E00000, 32'h48E00000, 32'h0, NV);
`ifdef POSIT_TOP_CLASSIFY_EN
    issue("cls_pos",  CLASSIFY, RNE, 32'h68E00000, 32'h0, 32'h4, 5'b0);
    issue("cls_zero", CLASSIFY, RNE, 32'h00000000, 32'h0, 32'h1, 5'b0);
    issue("cls_nar",  CLASSIFY, RNE, NAR,          32'h0, 32'h2, 5'b0);
    issue("cls_neg",  CLASSIFY, RNE, 32'h97200000, 32'h0, 32'h8, 5'b0);
`else
    issue("cls_pos",  CLASSIFY, RNE, 32'h68E00000, 32'h0, NAR, NV);
    issue("cls_zero", CLASSIFY, RNE, 32'h00000000, 32'h0, NAR, NV);
`endif
    issue("div",     DIV,   RNE, 32'h0, 32'h48E00000, NAR, NV);
    issue("sqrt",    SQRT,  RNE, 32'h0, 32'h48E00000, NAR, NV);
    issue("fmadd",   FMADD, RNE, 32'h48E00000, 32'h48E00000, NAR, NV);
    issue("mul",     MUL,   RTZ, 32'h48E00000, 32'h48E00000, NAR, NV);
    issue("undef_op", operation_e'(4'd12), RNE, 32'h48E00000, 32'h0, NAR, NV);
    idle(2);

    // Backpressure: result A held while the sink stalls, B waits for in_ready.
    out_ready = 1'b0;
    issue("bp_a", MINMAX, RTZ, 32'h68E00000, 32'h48E00000, 32'h68E00000, 5'b0);
    operands[0] = 32'h68E00000; operands[1] = 32'h48E00000;
    op = SGNJ; rnd_mode = RTZ; tag_in = ~tag_in; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bp_in_ready", W'(in_ready), 0);
      check("bp_hold", result, 32'h68E00000);
      check("bp_busy", W'(busy), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", W'(in_ready), 1);
    e.name = "bp_b"; e.res = 32'h97200000; e.st = 5'b0; e.tag = tag_in;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);

    // Flush discards the pending result and blocks a simultaneous input.
    out_ready = 1'b0;
    issue("fl_c", CMP, RNE, 32'h1, 32'h2, 32'h1, 5'b0);
    operands[0] = 32'h5; op = CMP; rnd_mode = RDN; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", W'(out_valid), 0);
    check("flush_in_ready", W'(in_ready), 1);
    check("flush_sb_depth", W'(sb_q.size()), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    out_ready = 1'b1;
    idle(1);
    @(negedge clk);
    check("flush_no_accept", W'(out_valid), 0);
    @(posedge clk); #1;

    // Reset with a pending result and a competing input.
    out_ready = 1'b0;
    issue("rs_e", SGNJ, RTZ, 32'h68E00000, 32'h48E00000, 32'h97200000, 5'b0);
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", W'(out_valid), 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_status", W'(5'(status)), 0);
    check("mid_rst_tag", W'(tag_out), 0);
    check("mid_rst_busy", W'(busy), 0);
    check("mid_rst_in_ready", W'(in_ready), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    issue("post_rst", MINMAX, RNE, 32'h97200000, 32'h48E00000, 32'h97200000, 5'b0);
    idle(3);

    check("sb_drained", W'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
